// File: rtl/serial_add_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_sub_pkg
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the add/subtract select encoding.
// -----------------------------------------------------------------------------
package serial_add_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : serial_add_sub_pkg

// File: rtl/serial_add_sub_full_adder_bit.sv
// -----------------------------------------------------------------------------
// full_adder_bit
// Combinational 1-bit full adder whose B input can be inverted, so the same
// cell serves both addition and subtraction (A + ~B + carry).
//
// Ports:
//   a    in   operand A bit
//   b    in   operand B bit (before optional inversion)
//   inv  in   1 = use ~b
//   cin  in   carry in
//   s    out  sum bit
//   cout out  carry out
// -----------------------------------------------------------------------------
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic inv,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic b_eff;
    logic p;

    assign b_eff = b ^ inv;
    assign p     = a ^ b_eff;
    assign s     = p ^ cin;
    assign cout  = (a & b_eff) | (p & cin);

endmodule : full_adder_bit

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor. Operands are captured on an accepted start,
// processed one bit per clock LSB first through a single full-adder cell,
// and the result is published together with a one-cycle done pulse.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   synchronous active-high reset
//   start     in   request, sampled only while idle
//   A, B      in   WIDTH-bit operands, captured on accepted start
//   Cin       in   carry-in (add) / borrow-in (subtract), captured on start
//   select    in   0 = add, 1 = subtract, captured on start
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse, results valid in that cycle
//   Sum       out  WIDTH-bit result, held until the next completion
//   Cout      out  carry-out (add) / not-borrow (subtract)
//   Overflow  out  signed overflow of the WIDTH-bit result
// -----------------------------------------------------------------------------
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             select,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic               sel_q,     sel_d;
    logic               carry_q,   carry_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;      // result being assembled
    logic               ovf_acc_q, ovf_acc_d;  // overflow captured at the MSB
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic               cout_q,    cout_d;
    logic               ovf_q,     ovf_d;

    logic fa_s;
    logic fa_cout;
    logic last_bit;

    // Operand registers shift right, so the bit under work is always bit 0.
    full_adder_bit u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .inv  (sel_q),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every signal driven here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        done_d    = 1'b0;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    sel_d   = select;
                    // Subtraction is A + ~B + ~Cin, so the borrow-in is inverted.
                    carry_d = Cin ^ (select == OP_SUB);
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // New sum bit enters at the MSB; after WIDTH shifts bit 0 is in place.
                acc_d   = (acc_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_cout;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    // carry_q is the carry into the MSB here.
                    ovf_acc_d = carry_q ^ fa_cout;
                    state_d   = ST_DONE;
                end
            end

            ST_DONE: begin
                sum_d   = acc_q;
                cout_d  = carry_q;
                ovf_d   = ovf_acc_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sel_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            done_q    <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            done_q    <= done_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = done_q;
    assign Sum      = sum_q;
    assign Cout     = cout_q;
    assign Overflow = ovf_q;

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Directed bench for serial_add_sub at WIDTH=2. Stimulus pushes hand-computed
// results into a scoreboard queue; a monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    localparam int W = 2;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         select;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;

    int           checks;
    int           errors;
    exp_t         sb_q[$];
    logic [W-1:0] prev_sum;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .select   (select),
        .busy     (busy),
        .done     (done),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum",      32'(Sum),      32'(e.sum));
                check("cout",     32'(Cout),     32'(e.cout));
                check("overflow", 32'(Overflow), 32'(e.ovf));
            end
        end
    end

    // One operation: checks done latency, busy length, and that Sum is held
    // during the shift. With interfere set, start and the operands are
    // disturbed during the first SHIFT cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sel,
                          input logic [W-1:0] es, input logic ec, input logic eo,
                          input bit interfere, input string tag);
        exp_t e;
        int   busy_cnt;
        int   done_cyc;
        int   extra_done;
        bit   sum_held;

        @(negedge clk);
        A = a; B = b; Cin = cin; select = sel; start = 1'b1;
        e.sum = es; e.cout = ec; e.ovf = eo;
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;

        busy_cnt = 0;
        done_cyc = 0;
        sum_held = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (interfere && k == 1) begin
                start = 1'b1; A = ~a; B = ~b; select = ~sel; Cin = ~cin;
            end
            if (interfere && k == 2) start = 1'b0;
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (done !== 1'b1 && Sum !== prev_sum) sum_held = 1'b0;
            if (done === 1'b1) begin
                done_cyc = k;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(W + 2));
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, "_sum_held"}, 32'(sum_held), 32'd1);
        prev_sum = es;

        if (interfere) begin
            extra_done = 0;
            for (int k = 0; k < W + 4; k++) begin
                @(negedge clk);
                if (done === 1'b1) extra_done++;
            end
            check({tag, "_extra_done"}, 32'(extra_done), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   d1;
        int   d2;
        int   stray;

        checks = 0;
        errors = 0;
        prev_sum = '0;
        reset = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; select = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_done", 32'(done),     32'd0);
        check("rst_sum",  32'(Sum),      32'd0);
        check("rst_cout", 32'(Cout),     32'd0);
        check("rst_ovf",  32'(Overflow), 32'd0);

        //        A      B      Cin   sel   Sum    Cout  Ovf
        run_op(2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, "add_01_01");
        run_op(2'b11, 2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0, "add_11_10");
        run_op(2'b11, 2'b11, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, "add_11_11");
        run_op(2'b10, 2'b01, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0, "sub_10_01");
        run_op(2'b01, 2'b10, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0, "sub_01_10");
        run_op(2'b11, 2'b11, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b0, "add_wrap");
        run_op(2'b11, 2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0, "sub_cin");
        run_op(2'b10, 2'b00, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, "ignore_start");

        // start held high: second operation accepted W+2 cycles after the first.
        @(negedge clk);
        A = 2'b01; B = 2'b10; Cin = 1'b0; select = 1'b0; start = 1'b1;
        e.sum = 2'b11; e.cout = 1'b0; e.ovf = 1'b0;
        sb_q.push_back(e);
        sb_q.push_back(e);
        @(posedge clk); #1;
        d1 = 0;
        d2 = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (d1 == 0) d1 = k;
                else begin
                    d2 = k;
                    break;
                end
            end
            @(posedge clk); #1;
            if (d1 != 0) start = 1'b0;
        end
        start = 1'b0;
        check("held_first_done", 32'(d1), 32'(W + 2));
        check("held_spacing", 32'(d2 - d1), 32'(W + 2));
        prev_sum = 2'b11;

        // Reset in the first SHIFT cycle aborts the operation.
        @(negedge clk);
        A = 2'b11; B = 2'b01; Cin = 1'b0; select = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy),     32'd0);
        check("abort_done", 32'(done),     32'd0);
        check("abort_sum",  32'(Sum),      32'd0);
        check("abort_cout", 32'(Cout),     32'd0);
        check("abort_ovf",  32'(Overflow), 32'd0);
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done === 1'b1) stray++;
        end
        check("abort_no_done", 32'(stray), 32'd0);
        prev_sum = '0;

        run_op(2'b01, 2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, "after_abort");

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_serial_add_sub
